// File: rtl/neureka_streamout_sequencer.sv
// Drains the per-PE accumulator streams onto the single store-out stream,
// in ascending PE order over the enabled mask, with multi-beat PEs and a tail strobe.
module neureka_streamout_sequencer #(
  parameter  int NR_PE   = 9,
  parameter  int DW      = 256,
  parameter  int MAX_BPP = 4,
  localparam int BW      = (MAX_BPP > 1) ? $clog2(MAX_BPP) : 1,
  localparam int PW      = (NR_PE > 1) ? $clog2(NR_PE) : 1,
  localparam int SW      = DW / 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic [NR_PE-1:0]    pe_mask_i,
  input  logic [BW-1:0]       bpp_i,
  input  logic [SW-1:0]       last_strb_i,
  input  logic [NR_PE-1:0]    push_valid_i,
  output logic [NR_PE-1:0]    push_ready_o,
  input  logic [NR_PE*DW-1:0] push_data_i,
  output logic                pop_valid_o,
  input  logic                pop_ready_i,
  output logic [DW-1:0]       pop_data_o,
  output logic [SW-1:0]       pop_strb_o,
  output logic                pop_last_o,
  output logic [PW-1:0]       pop_pe_o,
  output logic                busy_o,
  output logic                done_o
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    cur_pe_q, cur_pe_d;
  logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [BW-1:0]    bpp_q, bpp_d;
  logic [NR_PE-1:0] mask_q, mask_d;
  logic [SW-1:0]    strb_q, strb_d;

  logic [PW-1:0]    first_pe;
  logic [PW-1:0]    next_pe;
  logic             next_found;
  logic             cur_valid;
  logic             streaming;
  logic             last_beat;
  logic             hs;

  assign streaming = (state_q == STREAM);
  assign last_beat = (beat_cnt_q == bpp_q);

  // Descending scan so the lowest qualifying index wins.
  always_comb begin
    first_pe     = '0;
    next_pe      = '0;
    next_found   = 1'b0;
    cur_valid    = 1'b0;
    pop_data_o   = '0;
    push_ready_o = '0;
    for (int i = NR_PE - 1; i >= 0; i--) begin
      if (pe_mask_i[i]) begin
        first_pe = PW'(i);
      end
      if (mask_q[i] && (PW'(i) > cur_pe_q)) begin
        next_found = 1'b1;
        next_pe    = PW'(i);
      end
      if (PW'(i) == cur_pe_q) begin
        cur_valid       = push_valid_i[i];
        pop_data_o      = push_data_i[i*DW +: DW];
        push_ready_o[i] = streaming & pop_ready_i;
      end
    end
  end

  assign pop_valid_o = streaming & cur_valid;
  assign hs          = pop_valid_o & pop_ready_i;
  assign pop_strb_o  = (streaming && last_beat) ? strb_q : '1;
  assign pop_last_o  = streaming & last_beat & ~next_found;
  assign pop_pe_o    = cur_pe_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    cur_pe_d   = cur_pe_q;
    beat_cnt_d = beat_cnt_q;
    mask_d     = mask_q;
    bpp_d      = bpp_q;
    strb_d     = strb_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          mask_d     = pe_mask_i;
          bpp_d      = bpp_i;
          strb_d     = last_strb_i;
          cur_pe_d   = first_pe;
          beat_cnt_d = '0;
          state_d    = (|pe_mask_i) ? STREAM : DONE;
        end
      end
      STREAM: begin
        if (hs) begin
          if (!last_beat) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end else begin
            beat_cnt_d = '0;
            if (next_found) begin
              cur_pe_d = next_pe;
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst_i || clear_i) begin
      state_d    = IDLE;
      cur_pe_d   = '0;
      beat_cnt_d = '0;
      mask_d     = '0;
      bpp_d      = '0;
      strb_d     = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    state_q    <= state_d;
    cur_pe_q   <= cur_pe_d;
    beat_cnt_q <= beat_cnt_d;
    mask_q     <= mask_d;
    bpp_q      <= bpp_d;
    strb_q     <= strb_d;
  end

endmodule

// File: tb/tb_neureka_streamout_sequencer.sv
// Directed bench for the streamout sequencer: job table plus
// hand-written reset, clear and clear-with-start sequences.
module tb_neureka_streamout_sequencer;

  localparam int NR_PE   = 9;
  localparam int DW      = 256;
  localparam int MAX_BPP = 4;
  localparam int BW      = 2;
  localparam int PW      = 4;
  localparam int SW      = DW / 8;

  logic                clk = 1'b0;
  logic                rst_i;
  logic                clear_i;
  logic                start_i;
  logic [NR_PE-1:0]    pe_mask_i;
  logic [BW-1:0]       bpp_i;
  logic [SW-1:0]       last_strb_i;
  logic [NR_PE-1:0]    push_valid_i;
  logic [NR_PE-1:0]    push_ready_o;
  logic [NR_PE*DW-1:0] push_data_i;
  logic                pop_valid_o;
  logic                pop_ready_i;
  logic [DW-1:0]       pop_data_o;
  logic [SW-1:0]       pop_strb_o;
  logic                pop_last_o;
  logic [PW-1:0]       pop_pe_o;
  logic                busy_o;
  logic                done_o;

  neureka_streamout_sequencer #(
    .NR_PE  (NR_PE),
    .DW     (DW),
    .MAX_BPP(MAX_BPP)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .pe_mask_i   (pe_mask_i),
    .bpp_i       (bpp_i),
    .last_strb_i (last_strb_i),
    .push_valid_i(push_valid_i),
    .push_ready_o(push_ready_o),
    .push_data_i (push_data_i),
    .pop_valid_o (pop_valid_o),
    .pop_ready_i (pop_ready_i),
    .pop_data_o  (pop_data_o),
    .pop_strb_o  (pop_strb_o),
    .pop_last_o  (pop_last_o),
    .pop_pe_o    (pop_pe_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] pe;
    logic [BW-1:0] beat;
    logic [SW-1:0] strb;
    logic          last;
  } beat_t;

  typedef struct {
    logic [NR_PE-1:0] mask;
    logic [BW-1:0]    bpp;
    logic [SW-1:0]    strb;
    bit               stall;
    bit               mid;
    int               exp_beats;
  } job_t;

  beat_t expq[$];
  job_t  jobs[6];
  int    pe_idx[NR_PE];
  int    checks = 0;
  int    passed = 0;
  int    cyc = 0;
  int    last_evt;
  int    done_cyc;
  int    beats;

  function automatic logic [DW-1:0] mk(int pe, int idx);
    logic [31:0] w;
    w = {8'(pe), 8'(idx), 16'hC0DE};
    return {8{w}};
  endfunction

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic build(logic [NR_PE-1:0] m, logic [BW-1:0] b, logic [SW-1:0] s);
    beat_t e;
    int hi;
    expq.delete();
    hi = -1;
    for (int i = 0; i < NR_PE; i++) if (m[i]) hi = i;
    for (int i = 0; i < NR_PE; i++) begin
      if (m[i]) begin
        for (int k = 0; k <= int'(b); k++) begin
          e.pe   = PW'(i);
          e.beat = BW'(k);
          e.strb = (k == int'(b)) ? s : '1;
          e.last = (k == int'(b)) && (i == hi);
          expq.push_back(e);
        end
      end
    end
    for (int i = 0; i < NR_PE; i++) pe_idx[i] = 0;
    beats    = 0;
    done_cyc = -1;
  endtask

  task automatic cycle(input bit st, input bit stall);
    beat_t e;
    @(posedge clk);
    #1;
    cyc++;
    start_i     = st;
    pop_ready_i = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
    for (int i = 0; i < NR_PE; i++) begin
      push_valid_i[i] = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      push_data_i[i*DW +: DW] = mk(i, pe_idx[i]);
    end
    @(negedge clk);
    chk("ready_onehot", DW'(push_ready_o & ~(NR_PE'(1) << pop_pe_o)), '0);
    if (pop_valid_o && pop_ready_i) begin
      last_evt = cyc;
      beats++;
      chk("beat_expected", DW'(expq.size() != 0), DW'(1));
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("beat_pe", DW'(pop_pe_o), DW'(e.pe));
        chk("beat_data", pop_data_o, mk(e.pe, e.beat));
        chk("beat_strb", DW'(pop_strb_o), DW'(e.strb));
        chk("beat_last", DW'(pop_last_o), DW'(e.last));
      end
    end
    for (int i = 0; i < NR_PE; i++)
      if (push_valid_i[i] && push_ready_o[i]) pe_idx[i]++;
    if (done_o && done_cyc < 0) done_cyc = cyc;
  endtask

  task automatic run_job(job_t j);
    int  start_cyc;
    bit  injected;
    build(j.mask, j.bpp, j.strb);
    pe_mask_i   = j.mask;
    bpp_i       = j.bpp;
    last_strb_i = j.strb;
    cycle(1'b1, j.stall);
    start_cyc = cyc;
    last_evt  = cyc;
    chk("start_cycle_valid", DW'(pop_valid_o), '0);
    injected = 1'b0;
    for (int n = 0; n < 400 && done_cyc < 0; n++) begin
      if (j.mid && beats == 3 && !injected) begin
        pe_mask_i   = 9'h1FF;
        bpp_i       = '0;
        last_strb_i = '0;
        injected    = 1'b1;
        cycle(1'b1, j.stall);
      end else begin
        cycle(1'b0, j.stall);
      end
      chk("busy_in_job", DW'(busy_o), DW'(1));
    end
    chk("done_seen", DW'(done_cyc >= 0), DW'(1));
    chk("beat_count", DW'(beats), DW'(j.exp_beats));
    chk("beats_left", DW'(expq.size()), '0);
    chk("done_after_last", DW'(done_cyc), DW'(last_evt + 1));
    if (!j.stall) chk("job_latency", DW'(done_cyc - start_cyc), DW'(j.exp_beats + 1));
    cycle(1'b0, 1'b0);
    chk("busy_fall", DW'(busy_o), '0);
    chk("done_pulse_len", DW'(done_o), '0);
    chk("idle_valid", DW'(pop_valid_o), '0);
  endtask

  task automatic chk_reset_outs(string tag);
    chk({tag, "_valid"}, DW'(pop_valid_o), '0);
    chk({tag, "_push_ready"}, DW'(push_ready_o), '0);
    chk({tag, "_strb"}, DW'(pop_strb_o), DW'({SW{1'b1}}));
    chk({tag, "_last"}, DW'(pop_last_o), '0);
    chk({tag, "_pe"}, DW'(pop_pe_o), '0);
    chk({tag, "_busy"}, DW'(busy_o), '0);
    chk({tag, "_done"}, DW'(done_o), '0);
  endtask

  initial begin
    jobs[0] = '{mask: 9'h1FF, bpp: 2'd0, strb: '1,            stall: 0, mid: 0, exp_beats: 9};
    jobs[1] = '{mask: 9'h0A5, bpp: 2'd3, strb: 32'h0000FFFF,  stall: 0, mid: 0, exp_beats: 16};
    jobs[2] = '{mask: 9'h1FF, bpp: 2'd0, strb: 32'h0F0F0F0F,  stall: 1, mid: 0, exp_beats: 9};
    jobs[3] = '{mask: 9'h000, bpp: 2'd2, strb: 32'h12345678,  stall: 0, mid: 0, exp_beats: 0};
    jobs[4] = '{mask: 9'h0A5, bpp: 2'd1, strb: 32'h000000FF,  stall: 1, mid: 1, exp_beats: 8};
    jobs[5] = '{mask: 9'h103, bpp: 2'd2, strb: 32'hF0F0F0F0,  stall: 1, mid: 0, exp_beats: 9};

    rst_i        = 1'b1;
    clear_i      = 1'b0;
    start_i      = 1'b0;
    pe_mask_i    = '0;
    bpp_i        = '0;
    last_strb_i  = '0;
    push_valid_i = '0;
    push_data_i  = '0;
    pop_ready_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outs("reset");
    @(posedge clk);
    #1 rst_i = 1'b0;

    // Abort after five of nine beats; no done pulse may follow.
    build(9'h1FF, 2'd0, '1);
    pe_mask_i   = 9'h1FF;
    bpp_i       = '0;
    last_strb_i = '1;
    cycle(1'b1, 1'b0);
    for (int n = 0; n < 20 && beats < 5; n++) cycle(1'b0, 1'b0);
    chk("beats_before_clear", DW'(beats), DW'(5));
    @(posedge clk);
    #1;
    clear_i     = 1'b1;
    pop_ready_i = 1'b0;
    @(negedge clk);
    chk("clear_cycle_done", DW'(done_o), '0);
    @(posedge clk);
    #1 clear_i = 1'b0;
    @(negedge clk);
    chk_reset_outs("after_clear");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("no_done_after_clear", DW'(done_o), '0);
    end

    // Clear wins over a simultaneous start.
    @(posedge clk);
    #1;
    clear_i   = 1'b1;
    start_i   = 1'b1;
    pe_mask_i = 9'h1FF;
    @(posedge clk);
    #1;
    clear_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    chk("clear_start_busy", DW'(busy_o), '0);
    chk("clear_start_valid", DW'(pop_valid_o), '0);

    for (int t = 0; t < 6; t++) run_job(jobs[t]);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
